// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS mode enum, fixed symbol tables and popcount helper
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL  = 3'd0,
      MODE_VIDEO = 3'd1,
      MODE_TERC4 = 3'd2,
      MODE_VGB   = 3'd3,
      MODE_DGB   = 3'd4
   } tmds_mode_t;

   localparam logic [9:0] CTRL_CODE [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   localparam logic [9:0] TERC4_CODE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [9:0] VGB_CODE [3] = '{
      10'b1011001100, 10'b0100110011, 10'b1011001100
   };

   // Lane 0 data guard band is TERC4-coded from ctrl, so its slot is never selected.
   localparam logic [9:0] DGB_CODE [3] = '{
      10'b0000000000, 10'b0100110011, 10'b0100110011
   };

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// rtl/tmds_qm_stage.sv - combinational 8-to-9-bit transition-minimising stage with q_m ones count
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic [7:0] data,
   output logic [8:0] qm,
   output logic [3:0] n1
);

   always_comb begin : qm_calc
      logic [3:0] ones;
      logic       use_xnor;
      logic [8:0] q;
      ones     = popcount8(data);
      use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
      q        = '0;
      q[0]     = data[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ data[i]) : (q[i-1] ^ data[i]);
      end
      q[8] = ~use_xnor;
      qm   = q;
      n1   = popcount8(q[7:0]);
   end

endmodule

// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - single-lane HDMI TMDS encoder, 2-stage pipeline
// Define TMDS_DISPARITY_MON_EN to add the disparity and disp_err monitor outputs.
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter int CHANNEL     = 0,
   parameter int COUNT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   ce,
   input  logic [2:0]             mode,
   input  logic [7:0]             pixel_data,
   input  logic [1:0]             ctrl,
   input  logic [3:0]             aux_data,
`ifdef TMDS_DISPARITY_MON_EN
   output logic [9:0]             encoded_data,
   output logic [COUNT_WIDTH-1:0] disparity,
   output logic                   disp_err
`else
   output logic [9:0]             encoded_data
`endif
);

   localparam logic [9:0] VGB_SYM = VGB_CODE[CHANNEL[1:0]];
   localparam logic [9:0] DGB_SYM = DGB_CODE[CHANNEL[1:0]];
   localparam logic signed [COUNT_WIDTH-1:0] TWO = COUNT_WIDTH'(2);

   tmds_mode_t mode_q;
   logic [1:0] ctrl_q;
   logic [3:0] aux_q;
   logic [8:0] qm_q;
   logic [3:0] n1_q;
   logic [8:0] qm;
   logic [3:0] n1;
   logic signed [COUNT_WIDTH-1:0] cnt;
   logic signed [COUNT_WIDTH-1:0] cnt_nx;
   logic signed [COUNT_WIDTH-1:0] bal;
   logic [9:0] sym_nx;

   tmds_qm_stage u_qm (
      .data (pixel_data),
      .qm   (qm),
      .n1   (n1)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mode_q <= MODE_CTRL;
         ctrl_q <= 2'b00;
         aux_q  <= 4'h0;
         qm_q   <= '0;
         n1_q   <= '0;
      end else if (ce) begin
         mode_q <= (mode > 3'd4) ? MODE_CTRL : tmds_mode_t'(mode);
         ctrl_q <= ctrl;
         aux_q  <= aux_data;
         qm_q   <= qm;
         n1_q   <= n1;
      end
   end

   // bal = N1 - N0 = 2*N1 - 8; cnt's sign bit gives negativity, cnt==0 is handled first.
   always_comb begin
      bal    = COUNT_WIDTH'({n1_q, 1'b0}) - COUNT_WIDTH'(8);
      sym_nx = CTRL_CODE[ctrl_q];
      cnt_nx = '0;
      case (mode_q)
         MODE_VIDEO: begin
            if ((cnt == '0) || (n1_q == 4'd4)) begin
               sym_nx = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
               cnt_nx = qm_q[8] ? (cnt + bal) : (cnt - bal);
            end else if ((!cnt[COUNT_WIDTH-1] && (n1_q > 4'd4)) ||
                         (cnt[COUNT_WIDTH-1] && (n1_q < 4'd4))) begin
               sym_nx = {1'b1, qm_q[8], ~qm_q[7:0]};
               cnt_nx = cnt + (qm_q[8] ? TWO : '0) - bal;
            end else begin
               sym_nx = {1'b0, qm_q[8], qm_q[7:0]};
               cnt_nx = cnt + bal - (qm_q[8] ? '0 : TWO);
            end
         end
         MODE_TERC4: sym_nx = TERC4_CODE[aux_q];
         MODE_VGB:   sym_nx = VGB_SYM;
         MODE_DGB:   sym_nx = (CHANNEL == 0) ? TERC4_CODE[{2'b11, ctrl_q}] : DGB_SYM;
         default:    sym_nx = CTRL_CODE[ctrl_q];
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         encoded_data <= CTRL_CODE[0];
         cnt          <= '0;
      end else if (ce) begin
         encoded_data <= sym_nx;
         cnt          <= cnt_nx;
      end
   end

`ifdef TMDS_DISPARITY_MON_EN
   localparam logic signed [COUNT_WIDTH-1:0] ERR_LIM = COUNT_WIDTH'(10);

   assign disparity = cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         disp_err <= 1'b0;
      end else if (ce && (mode_q == MODE_VIDEO) && ((cnt_nx > ERR_LIM) || (cnt_nx < -ERR_LIM))) begin
         disp_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - table and scoreboard bench for lanes 0 and 1 of the TMDS encoder
module tb_tmds_channel_encoder;

   localparam logic [9:0] CTRL00 = 10'b1101010100;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       ce = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] pixel_data = 8'h00;
   logic [1:0] ctrl = 2'b00;
   logic [3:0] aux_data = 4'h0;
   logic [9:0] enc0;
   logic [9:0] enc1;
`ifdef TMDS_DISPARITY_MON_EN
   logic [4:0] disp0;
   logic [4:0] disp1;
   logic       err0;
   logic       err1;
`endif

   always #5 clk = ~clk;

   tmds_channel_encoder #(.CHANNEL(0), .COUNT_WIDTH(5)) dut0 (
      .clk(clk), .n_rst(n_rst), .ce(ce), .mode(mode), .pixel_data(pixel_data),
      .ctrl(ctrl), .aux_data(aux_data),
`ifdef TMDS_DISPARITY_MON_EN
      .disparity(disp0), .disp_err(err0),
`endif
      .encoded_data(enc0)
   );

   tmds_channel_encoder #(.CHANNEL(1), .COUNT_WIDTH(5)) dut1 (
      .clk(clk), .n_rst(n_rst), .ce(ce), .mode(mode), .pixel_data(pixel_data),
      .ctrl(ctrl), .aux_data(aux_data),
`ifdef TMDS_DISPARITY_MON_EN
      .disparity(disp1), .disp_err(err1),
`endif
      .encoded_data(enc1)
   );

   typedef struct {
      logic [9:0] e0;
      logic [9:0] e1;
      int         cnt;
      bit         err;
   } exp_t;

   typedef struct {
      logic [2:0] md;
      logic [7:0] pix;
      logic [1:0] c;
      logic [3:0] ax;
      logic [9:0] e0;
      logic [9:0] e1;
   } vec_t;

   logic [9:0] ctrl_tb [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   vec_t tbl [17];
   exp_t sb[$];
   exp_t last;
   exp_t rst_e;
   int   errors = 0;
   int   checks = 0;
   int   m_cnt = 0;
   bit   m_err = 1'b0;
   int   n_en = 0;
   bit   last_ce = 1'b0;

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
      end
   endtask

   task automatic chk_mon(input int cnt_want, input bit err_want);
`ifdef TMDS_DISPARITY_MON_EN
      logic [4:0] w;
      w = cnt_want[4:0];
      chk("disparity0", {5'd0, disp0}, {5'd0, w});
      chk("disparity1", {5'd0, disp1}, {5'd0, w});
      chk("disp_err0", {9'd0, err0}, {9'd0, err_want});
      chk("disp_err1", {9'd0, err1}, {9'd0, err_want});
`else
      if (cnt_want > 99 || err_want > 1'b1) $display("unexpected model state");
`endif
   endtask

   // Reference video encoder, written straight from the DVI algorithm on ints.
   task automatic model(input logic [2:0] md, input logic [7:0] pix, input logic [1:0] c,
                        output logic [9:0] sym);
      logic [8:0] qm;
      bit         use_xnor;
      int         n1;
      int         nd;
      sym = 'x;
      if (md == 3'd1) begin
         use_xnor = ($countones(pix) > 4) || ($countones(pix) == 4 && pix[0] == 1'b0);
         qm[0] = pix[0];
         for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ pix[i]) : (qm[i-1] ^ pix[i]);
         qm[8] = !use_xnor;
         n1 = $countones(qm[7:0]);
         nd = n1 - (8 - n1);
         if (m_cnt == 0 || nd == 0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_cnt = m_cnt + (qm[8] ? nd : -nd);
         end else if ((m_cnt > 0 && nd > 0) || (m_cnt < 0 && nd < 0)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            m_cnt = m_cnt + (qm[8] ? 2 : 0) - nd;
         end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            m_cnt = m_cnt + nd - (qm[8] ? 0 : 2);
         end
         if (m_cnt > 10 || m_cnt < -10) m_err = 1'b1;
      end else begin
         if (md == 3'd0 || md > 3'd4) sym = ctrl_tb[c];
         m_cnt = 0;
      end
   endtask

   task automatic sample();
      if (last_ce) begin
         n_en++;
         if (n_en >= 2 && sb.size() > 0) last = sb.pop_front();
      end
      chk("enc0", enc0, last.e0);
      chk("enc1", enc1, last.e1);
      chk_mon(last.cnt, last.err);
   endtask

   task automatic step(input bit ce_v, input logic [2:0] md, input logic [7:0] pix,
                       input logic [1:0] c, input logic [3:0] ax, input bit use_tbl,
                       input logic [9:0] t0, input logic [9:0] t1, input bit do_rst);
      logic [9:0] sym;
      exp_t       e;
      @(negedge clk);
      sample();
      if (do_rst) begin
         #1 n_rst = 1'b0;
         #1;
         chk("rst_mid_enc0", enc0, CTRL00);
         chk("rst_mid_enc1", enc1, CTRL00);
         chk_mon(0, 1'b0);
         n_rst = 1'b1;
         sb.delete();
         n_en = 0;
         m_cnt = 0;
         m_err = 1'b0;
         last = rst_e;
      end
      #1;
      ce = ce_v;
      mode = md;
      pixel_data = pix;
      ctrl = c;
      aux_data = ax;
      if (ce_v) begin
         model(md, pix, c, sym);
         e.e0 = use_tbl ? t0 : sym;
         e.e1 = use_tbl ? t1 : sym;
         e.cnt = m_cnt;
         e.err = m_err;
         sb.push_back(e);
      end
      last_ce = ce_v;
   endtask

   initial begin
      logic [2:0] md;
      int         r;
      tbl = '{
         '{3'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000},
         '{3'd1, 8'h00, 2'b00, 4'h0, 10'b1111111111, 10'b1111111111},
         '{3'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000},
         '{3'd0, 8'h00, 2'b11, 4'h0, 10'b1010101011, 10'b1010101011},
         '{3'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000},
         '{3'd0, 8'h5a, 2'b00, 4'h3, 10'b1101010100, 10'b1101010100},
         '{3'd0, 8'h00, 2'b01, 4'h0, 10'b0010101011, 10'b0010101011},
         '{3'd0, 8'h00, 2'b10, 4'h0, 10'b0101010100, 10'b0101010100},
         '{3'd2, 8'h00, 2'b00, 4'h0, 10'b1010011100, 10'b1010011100},
         '{3'd2, 8'h00, 2'b00, 4'hf, 10'b1011000011, 10'b1011000011},
         '{3'd2, 8'hff, 2'b11, 4'h5, 10'b0100011110, 10'b0100011110},
         '{3'd3, 8'h00, 2'b00, 4'h0, 10'b1011001100, 10'b0100110011},
         '{3'd4, 8'h00, 2'b10, 4'h0, 10'b0101100011, 10'b0100110011},
         '{3'd4, 8'h00, 2'b01, 4'h7, 10'b1001110001, 10'b0100110011},
         '{3'd5, 8'h00, 2'b01, 4'h0, 10'b0010101011, 10'b0010101011},
         '{3'd7, 8'h00, 2'b10, 4'h0, 10'b0101010100, 10'b0101010100},
         '{3'd1, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000}
      };
      rst_e = '{CTRL00, CTRL00, 0, 1'b0};
      last = rst_e;

      mode = 3'd1;
      pixel_data = 8'ha5;
      #1 n_rst = 1'b0;
      #2;
      chk("rst_enc0", enc0, CTRL00);
      chk("rst_enc1", enc1, CTRL00);
      chk_mon(0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      foreach (tbl[i]) step(1'b1, tbl[i].md, tbl[i].pix, tbl[i].c, tbl[i].ax, 1'b1, tbl[i].e0, tbl[i].e1, 1'b0);

      for (int i = 0; i < 70; i++) begin
         r = $urandom_range(0, 9);
         md = (r == 0) ? 3'd0 : (r == 1) ? 3'd6 : 3'd1;
         step((i < 20 || i > 24), md, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 1'b0, 10'd0, 10'd0, (i == 45));
      end
      for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'h00, 2'b00, 4'h0, 1'b0, 10'd0, 10'd0, 1'b0);
      @(negedge clk);
      sample();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Complete single-lane HDMI TMDS encoder, the successor to the video-only 8b/10b pixel encoder.
- Adds per-cycle mode selection between video data, control, TERC4 data island, and video/data-island guard bands.
- Adds a channel-specific guard-band pattern, a pixel clock enable and a fixed 2-stage pipeline.
- One instance per TMDS lane (ch0/1/2). Its output feeds the 10:1 serializer.

Parameters:
- CHANNEL, 0, lane index 0..2; selects guard-band patterns.
- COUNT_WIDTH, 5, width of the signed two's-complement running-disparity counter; minimum 5.

Ports:
- clk  input  1  pixel clock
- n_rst  input  1  asynchronous active-low reset
- ce  input  1  clock enable; low freezes all state
- mode  input  3  tmds_mode_t: CTRL=0, VIDEO=1, TERC4=2, VGB=3, DGB=4; values 5-7 are treated as CTRL
- pixel_data  input  8  video byte, used in VIDEO
- ctrl  input  2  {c1,c0}, used in CTRL and in CHANNEL 0 DGB
- aux_data  input  4  TERC4 nibble, used in TERC4
- encoded_data  output  10  TMDS symbol, bit 0 transmitted first

Behaviour:
- **Reset:** asynchronous, active-low. Clocking: single clk; all flops update only when ce=1.
- **Reset values:** encoded_data=10'b1101010100 (CTRL 00); disparity counter=0; stage-1 registers hold mode=CTRL, ctrl=00.
- **Latency:** exactly 2 enabled cycles. Inputs are sampled at edge N; the symbol appears at edge N+1; encoded_data is a flop output.
- **Stage 1, registered:**
  - Latch mode, ctrl and aux_data.
  - For video, compute q_m[8:0] and N1 = popcount(q_m[7:0]); N0 = 8 - N1.
  - XNOR chain with q_m[8]=0 when popcount(d)>4, or popcount(d)==4 and d[0]==0; otherwise XOR chain with q_m[8]=1.
- **Stage 2, VIDEO:** cnt is the signed counter; negativity is taken from cnt's sign bit.
  - If cnt==0 or N1==N0:
    - out={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (N1-N0) : (N0-N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out={1, q_m8, ~q_m[7:0]}.
    - cnt += 2*q_m8 + (N0-N1).
  - Else:
    - out={0, q_m8, q_m[7:0]}.
    - cnt += (N1-N0) - 2*~q_m8.
  - All arithmetic is sign-extended to COUNT_WIDTH and wraps modulo 2^COUNT_WIDTH. Valid DVI streams never reach ±16, so no saturation logic.
- **Stage 2, any non-VIDEO mode:** cnt is forced to 0 on that cycle.
  - CTRL: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - TERC4: 16-entry table (HDMI 1.4 table 5-18), e.g. 0→1010011100, F→1011000011.
  - VGB: CHANNEL 0 or 2 → 1011001100; CHANNEL 1 → 0100110011.
  - DGB: CHANNEL 0 → TERC4({2'b11, ctrl}); CHANNEL 1 or 2 → 0100110011.
- **Boundary cases:**
  - Mode change between any two cycles takes effect with the same 2-cycle latency; no bubbles.
  - A VIDEO→CTRL→VIDEO sequence restarts from cnt=0.
  - ce low for any duration: output and cnt hold; resume with no lost symbol.
  - Reset mid-stream: output becomes CTRL 00 immediately (async); the first post-reset symbol reflects inputs sampled at the first enabled edge after release.
  - Illegal mode values are encoded as CTRL.

Optional Feature:
- Macro: TMDS_DISPARITY_MON_EN.
- **When defined:**
  - Adds output disparity [COUNT_WIDTH-1:0], equal to the current cnt register.
  - Adds output disp_err [1], sticky, set when VIDEO-mode |cnt| > 10 after an update.
  - disp_err clears only on reset; both new outputs reset to 0.
- **When undefined:** neither port exists; logic and timing are identical otherwise.

Decomposition:
- Package tmds_pkg holds:
  - tmds_mode_t enum;
  - the CTRL code array [4][10];
  - the TERC4 table [16][10];
  - the VGB/DGB patterns indexed by channel;
  - function popcount8.
- One sub-module, tmds_qm_stage: combinational 8→9-bit transition-minimising stage with N1 output, instantiated in stage 1.

Test Plan:
- **Reset:** assert n_rst low with arbitrary inputs → encoded_data=10'b1101010100 immediately; with the monitor feature, disparity=0.
- **VIDEO disparity sequence:** pixel_data=8'h00 for 3 cycles from reset, ce=1 → outputs 10'b0100000000, 10'b1111111111, 10'b0100000000 on cycles 2, 3, 4; cnt = -8, +2, -6.
- **Counter reset on mode change:** VIDEO 8'h00 (cnt=-8), then CTRL ctrl=11 → 10'b1010101011 with cnt=0; then VIDEO 8'h00 → 10'b0100000000 again.
- **TERC4 and guard bands:**
  - TERC4 aux_data=0 → 1010011100; TERC4 aux_data=F → 1011000011.
  - CHANNEL=1 VGB → 0100110011.
  - CHANNEL=0 DGB ctrl=10 → 0101100011.
- **Clock enable:** drop ce for 5 cycles mid-VIDEO stream → output and cnt frozen; the symbol sequence after ce rises equals the uninterrupted reference model.
- **Reset mid-stream:** pulse n_rst low between clock edges during VIDEO → output snaps to CTRL 00, cnt=0; after release the 2-cycle latency restarts.
